// File: rtl/load_store_unit_if.sv
// CPU-side request/response bundle for the load/store unit.
// One request in flight; resp_* is a single-cycle completion pulse.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_size,
    output req_signed,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_size,
    input  req_signed,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a word-wide memory.
// Sub-word stores do read-modify-write; all memory outputs are registered.
module load_store_unit #(
  parameter int MEM_WORDS = 85
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus,
  output logic [31:0]        A,
  output logic [31:0]        WD,
  output logic               WE,
  input  logic [31:0]        RD
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RESP,
    ERR
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t      state;
  logic        we_q;
  logic        sgn_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;

  logic [31:0] req_idx;
  logic        req_err;
  logic        go_err;
  logic        go_load;
  logic        go_wst;
  logic        go_sst;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign bus.req_ready  = rst_n && (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  always_comb begin
    req_idx = {2'b00, bus.req_addr[31:2]};
    req_err = 1'b0;
    unique case (bus.req_size)
      SZ_B:    req_err = 1'b0;
      SZ_H:    req_err = bus.req_addr[0];
      SZ_W:    req_err = |bus.req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (req_idx >= 32'(MEM_WORDS))
      req_err = 1'b1;
  end

  // One-hot routing so the accept decoder stays truly unique
  always_comb begin
    go_err  = req_err;
    go_load = !req_err && !bus.req_we;
    go_wst  = !req_err && bus.req_we &&
              (bus.req_size == SZ_W);
    go_sst  = !req_err && bus.req_we &&
              (bus.req_size != SZ_W);
  end

  always_comb begin
    lane_b    = RD[{lane_q, 3'b000} +: 8];
    lane_h    = lane_q[1] ? RD[31:16] : RD[15:0];
    load_val  = RD;
    merge_val = RD;
    unique case (size_q)
      SZ_B: begin
        load_val = {{24{sgn_q & lane_b[7]}}, lane_b};
        merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_H: begin
        load_val = {{16{sgn_q & lane_h[15]}}, lane_h};
        merge_val[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      sgn_q        <= 1'b0;
      size_q       <= SZ_B;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      A            <= '0;
      WD           <= '0;
      WE           <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            sgn_q   <= bus.req_signed;
            size_q  <= bus.req_size;
            lane_q  <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata;
            unique case (1'b1)
              go_err: begin
                state        <= ERR;
                resp_valid_q <= 1'b1;
                resp_err_q   <= 1'b1;
                resp_rdata_q <= '0;
              end
              go_load: begin
                state <= READ;
                A     <= req_idx;
              end
              go_wst: begin
                state <= WRITE;
                A     <= req_idx;
                WD    <= bus.req_wdata;
                WE    <= 1'b1;
              end
              go_sst: begin
                state <= READ;
                A     <= req_idx;
              end
              default: state <= IDLE;
            endcase
          end
        end
        READ: begin
          if (!we_q) begin
            state        <= RESP;
            A            <= '0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_val;
          end else begin
            state <= WRITE;
            WD    <= merge_val;
            WE    <= 1'b1;
          end
        end
        WRITE: begin
          state        <= RESP;
          A            <= '0;
          WD           <= '0;
          WE           <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
        end
        RESP, ERR: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a behavioural memory.
// Checks latency, lane handling, errors, reset abort and back-to-back.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        WE;

  load_store_unit #(.MEM_WORDS(85)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .A     (A),
    .WD    (WD),
    .WE    (WE),
    .RD    (RD)
  );

  logic [31:0] mem [0:84];
  assign RD = (A < 32'd85) ? mem[A[6:0]] : 32'h0;

  int          tests = 0;
  int          failed = 0;
  int          we_cnt = 0;
  logic [31:0] last_a = '0;
  logic [31:0] last_wd = '0;

  always @(posedge clk) begin
    if (WE) begin
      we_cnt  <= we_cnt + 1;
      last_a  <= A;
      last_wd <= WD;
      if (A < 32'd85) mem[A[6:0]] <= WD;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic run(input logic we,
                     input logic [1:0] sz,
                     input logic sg,
                     input logic [31:0] addr,
                     input logic [31:0] wd,
                     output int lat,
                     output logic [31:0] rd,
                     output logic err);
    int g = 0;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    while (!bus.req_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rd  = bus.resp_rdata;
    err = bus.resp_err;
    chk("ready_with_resp", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
  endtask

  task automatic ld(input string tag,
                    input logic [1:0] sz,
                    input logic sg,
                    input logic [31:0] addr,
                    input logic [31:0] exp);
    int lat;
    logic [31:0] rd;
    logic err;
    run(1'b0, sz, sg, addr, 32'h0, lat, rd, err);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_data"}, rd, exp);
  endtask

  task automatic st(input string tag,
                    input logic [1:0] sz,
                    input logic [31:0] addr,
                    input logic [31:0] wd,
                    input int exp_lat,
                    input logic [31:0] exp_wd);
    int lat;
    int c0;
    logic [31:0] rd;
    logic err;
    c0 = we_cnt;
    run(1'b1, sz, 1'b0, addr, wd, lat, rd, err);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_rdata"}, rd, 32'h0);
    chk({tag, "_wepulses"}, 32'(we_cnt - c0), 32'd1);
    chk({tag, "_A"}, last_a, {2'b00, addr[31:2]});
    chk({tag, "_WD"}, last_wd, exp_wd);
  endtask

  task automatic bad(input string tag,
                     input logic we,
                     input logic [1:0] sz,
                     input logic [31:0] addr);
    int lat;
    int c0;
    logic [31:0] rd;
    logic err;
    c0 = we_cnt;
    run(we, sz, 1'b1, addr, 32'hFFFF_FFFF, lat, rd, err);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'h1);
    chk({tag, "_rdata"}, rd, 32'h0);
    chk({tag, "_noWE"}, 32'(we_cnt - c0), 32'd0);
  endtask

  int          cyc;
  int          nresp;
  int          acc [4];
  logic [31:0] resps [4];
  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_exp [4];

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.resp_valid) begin
      chk("b2b_ready_low", 32'(bus.req_ready), 32'h0);
      if (nresp < 4) resps[nresp] = bus.resp_rdata;
      nresp++;
    end
  endtask

  initial begin
    int c0;
    int g;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    b2b_addr = '{32'h10, 32'h14, 32'h20, 32'h150};
    b2b_exp  = '{32'h7FEF_F344, 32'h0BAD_C0DE,
                 32'hCAFE_F00D, 32'h1357_9BDF};

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_WE", 32'(WE), 32'h0);
    chk("rst_A", A, 32'h0);
    chk("rst_WD", WD, 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(bus.req_ready), 32'h1);

    st("sw_dead", 2'b10, 32'h10, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
    ld("lw_dead", 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);

    st("sw_1122", 2'b10, 32'h10, 32'h1122_3344, 2, 32'h1122_3344);
    st("sb_aa", 2'b00, 32'h11, 32'h0000_00AA, 3, 32'h1122_AA44);
    ld("lw_aa", 2'b10, 1'b0, 32'h10, 32'h1122_AA44);

    st("sw_f3", 2'b10, 32'h10, 32'h1122_F344, 2, 32'h1122_F344);
    ld("lb_s", 2'b00, 1'b1, 32'h11, 32'hFFFF_FFF3);
    ld("lbu", 2'b00, 1'b0, 32'h11, 32'h0000_00F3);
    ld("lh_s_pos", 2'b01, 1'b1, 32'h12, 32'h0000_1122);
    ld("lbu_l0", 2'b00, 1'b0, 32'h10, 32'h0000_0044);

    st("sh_hi", 2'b01, 32'h12, 32'h1234_BEEF, 3, 32'hBEEF_F344);
    ld("lh_s_neg", 2'b01, 1'b1, 32'h12, 32'hFFFF_BEEF);
    ld("lhu", 2'b01, 1'b0, 32'h12, 32'h0000_BEEF);
    ld("lh_s_lo", 2'b01, 1'b1, 32'h10, 32'hFFFF_F344);
    ld("lb_s_l3", 2'b00, 1'b1, 32'h13, 32'hFFFF_FFBE);
    st("sb_l3", 2'b00, 32'h13, 32'hFFFF_FF7F, 3, 32'h7FEF_F344);

    st("sw_w5", 2'b10, 32'h14, 32'h0BAD_C0DE, 2, 32'h0BAD_C0DE);
    st("sw_w8", 2'b10, 32'h20, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);
    st("sw_w84", 2'b10, 32'h150, 32'h1357_9BDF, 2, 32'h1357_9BDF);
    ld("lw_w84", 2'b10, 1'b0, 32'h150, 32'h1357_9BDF);

    bad("err_lh_odd", 1'b0, 2'b01, 32'h13);
    bad("err_lw_mis", 1'b0, 2'b10, 32'h16);
    bad("err_size3", 1'b0, 2'b11, 32'h10);
    bad("err_lw_oob", 1'b0, 2'b10, 32'h154);
    bad("err_sw_oob", 1'b1, 2'b10, 32'h154);
    bad("err_sb_oob", 1'b1, 2'b00, 32'h155);
    ld("after_err", 2'b10, 1'b0, 32'h10, 32'h7FEF_F344);

    c0 = we_cnt;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h1234_5678;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort_WE_before", 32'(WE), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_WE", 32'(WE), 32'h0);
    chk("abort_A", A, 32'h0);
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("abort_ready", 32'(bus.req_ready), 32'h0);
    repeat (2) @(negedge clk);
    chk("abort_no_write", 32'(we_cnt - c0), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_idle", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    ld("abort_keep", 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);

    cyc = 0;
    nresp = 0;
    for (int k = 0; k < 4; k++) begin
      bus.req_we    = 1'b0;
      bus.req_size  = 2'b10;
      bus.req_addr  = b2b_addr[k];
      bus.req_valid = 1'b1;
      g = 0;
      while (!bus.req_ready && g < 10) begin
        step();
        g++;
      end
      acc[k] = cyc;
      step();
    end
    bus.req_valid = 1'b0;
    g = 0;
    while (nresp < 4 && g < 10) begin
      step();
      g++;
    end
    chk("b2b_count", 32'(nresp), 32'd4);
    for (int k = 1; k < 4; k++)
      chk("b2b_spacing", 32'(acc[k] - acc[k-1]), 32'd3);
    for (int k = 0; k < 4; k++)
      chk("b2b_data", resps[k], b2b_exp[k]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
